// File: rtl/mem_load_store_unit_pkg.sv
// Shared definitions for the MEM-stage load/store unit.
//   mem_mode_e  : access size/signedness encodings carried on mem_mode
//   state_e     : sequencing states of the load/store FSM
//   BE_ALL      : all four byte lanes enabled
//   helpers     : size decode, split detection, load result extension
package mem_pkg;

  typedef enum logic [2:0] {
    MODE_WORD   = 3'b000,
    MODE_HALF_S = 3'b001,
    MODE_HALF_U = 3'b010,
    MODE_BYTE_S = 3'b011,
    MODE_BYTE_U = 3'b100
  } mem_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PH1  = 2'd1,
    ST_PH2  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  localparam logic [3:0] BE_ALL = 4'b1111;

  function automatic logic is_word(input logic [2:0] m);
    return m == MODE_WORD;
  endfunction

  function automatic logic is_half(input logic [2:0] m);
    return (m == MODE_HALF_S) || (m == MODE_HALF_U);
  endfunction

  function automatic logic is_byte(input logic [2:0] m);
    return (m == MODE_BYTE_S) || (m == MODE_BYTE_U);
  endfunction

  function automatic logic mode_legal(input logic [2:0] m);
    return m <= MODE_BYTE_U;
  endfunction

  // An access needs two word-bus beats when it crosses a word boundary.
  function automatic logic needs_split(input logic [2:0] m, input logic [1:0] off);
    return (is_half(m) && (off == 2'd3)) || (is_word(m) && (off != 2'd0));
  endfunction

  // Bytes arrive right-justified in address order; widen per mode.
  function automatic logic [31:0] extend_load(input logic [2:0] m, input logic [31:0] v);
    logic [31:0] r;
    case (m)
      MODE_HALF_S: r = {{16{v[15]}}, v[15:0]};
      MODE_HALF_U: r = {16'h0000, v[15:0]};
      MODE_BYTE_S: r = {{24{v[7]}}, v[7:0]};
      MODE_BYTE_U: r = {24'h000000, v[7:0]};
      default:     r = v;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mem_load_store_unit_if.sv
// Word-wide data memory bus between the load/store unit and memory.
//   bus_req/bus_we/bus_addr/bus_be/bus_wdata : driven by the initiator
//   bus_ready/bus_rdata                      : driven by the memory
// Big-endian lanes: bus_be[3] / bits [31:24] hold the lowest address.
interface mem_load_store_unit_if #(
  parameter int ADDR_W = 32
) ();

  logic              bus_req;
  logic              bus_we;
  logic [ADDR_W-1:0] bus_addr;
  logic [3:0]        bus_be;
  logic [31:0]       bus_wdata;
  logic              bus_ready;
  logic [31:0]       bus_rdata;

  modport master (
    output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    input  bus_ready, bus_rdata
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    output bus_ready, bus_rdata
  );

endinterface

// File: rtl/mem_load_store_unit_byte_lane.sv
// Combinational big-endian lane steering for one bus beat.
//   mode, offset, phase : access kind, address[1:0], 0=first beat 1=second
//   write_data          : right-justified store data
//   rdata               : word returned by memory for this beat
//   be, wdata           : byte enables and lane-positioned store data
//   ld_bytes, ld_count  : enabled read bytes packed right-justified in
//                         address order, and how many there were
module mem_byte_lane
  import mem_pkg::*;
(
  input  logic [2:0]  mode,
  input  logic [1:0]  offset,
  input  logic        phase,
  input  logic [31:0] write_data,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] ld_bytes,
  output logic [2:0]  ld_count
);

  logic [5:0] sh;

  assign sh = {1'b0, offset, 3'b000};

  always_comb begin
    be    = '0;
    wdata = '0;
    if (is_word(mode)) begin
      if (!phase) begin
        be    = BE_ALL >> offset;
        wdata = write_data >> sh;
      end else begin
        be    = ~(BE_ALL >> offset);
        wdata = write_data << (6'd32 - sh);
      end
    end else if (is_half(mode)) begin
      if (offset == 2'd3) begin
        if (!phase) begin
          be    = 4'b0001;
          wdata = {24'h000000, write_data[15:8]};
        end else begin
          be    = 4'b1000;
          wdata = {write_data[7:0], 24'h000000};
        end
      end else begin
        be    = 4'b1100 >> offset;
        wdata = {write_data[15:0], 16'h0000} >> sh;
      end
    end else if (is_byte(mode)) begin
      be    = 4'b1000 >> offset;
      wdata = {write_data[7:0], 24'h000000} >> sh;
    end

    // Walk lanes from lowest address (lane 3) so earlier bytes end up
    // more significant.
    ld_bytes = '0;
    ld_count = '0;
    for (int unsigned j = 0; j < 4; j++) begin
      if (be[3-j]) begin
        ld_bytes = {ld_bytes[23:0], rdata[8*(3-j) +: 8]};
        ld_count = ld_count + 3'd1;
      end
    end
  end

endmodule

// File: rtl/mem_load_store_unit.sv
// MEM-stage load/store initiator onto a word-wide big-endian memory bus.
//   clk, reset          : rising-edge clock, async active-high reset
//   mem_read/mem_write  : level requests held by the pipeline while stalled
//   mem_mode            : word / half s,u / byte s,u
//   address, write_data : byte address (any alignment), right-justified data
//   read_data           : extended load result, updated on completion
//   stall               : pipeline must hold its MEM inputs
//   done, mode_err      : completion pulse, and illegal-request flag with it
//   bus                 : master side of the data memory bus
module mem_load_store_unit
  import mem_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic [2:0]            mem_mode,
  input  logic [ADDR_W-1:0]     address,
  input  logic [31:0]           write_data,
  output logic [31:0]           read_data,
  output logic                  stall,
  output logic                  done,
  output logic                  mode_err,
  mem_load_store_unit_if.master bus
);

  state_e      state, state_next;

  logic        req, bad_req;
  logic [2:0]  mode_q;
  logic [1:0]  off_q;
  logic [31:0] wd_q;
  logic        we_q;
  logic        split_q;
  logic        err_q;
  logic [31:0] acc;

  logic [2:0]  drv_mode;
  logic [1:0]  drv_off;
  logic        drv_phase;
  logic [31:0] drv_wd;
  logic [3:0]  drv_be;
  logic [31:0] drv_wdata;
  logic [31:0] drv_ld_bytes;
  logic [2:0]  drv_ld_count;

  logic [3:0]  ld_be;
  logic [31:0] ld_wdata;
  logic [31:0] ld_bytes;
  logic [2:0]  ld_count;

  logic [31:0] assembled;
  logic        last_beat;
  logic        unused_lane;

  assign req     = mem_read || mem_write;
  assign bad_req = !mode_legal(mem_mode) || (mem_read && mem_write);

  // Two lane instances: one prepares the beat about to be launched (from
  // the raw inputs in IDLE, the latched request in PH1), the other decodes
  // the read data of the beat currently on the bus.
  always_comb begin
    if (state == ST_IDLE) begin
      drv_mode  = mem_mode;
      drv_off   = address[1:0];
      drv_phase = 1'b0;
      drv_wd    = write_data;
    end else begin
      drv_mode  = mode_q;
      drv_off   = off_q;
      drv_phase = 1'b1;
      drv_wd    = wd_q;
    end
  end

  mem_byte_lane u_lane_drive (
    .mode       (drv_mode),
    .offset     (drv_off),
    .phase      (drv_phase),
    .write_data (drv_wd),
    .rdata      (bus.bus_rdata),
    .be         (drv_be),
    .wdata      (drv_wdata),
    .ld_bytes   (drv_ld_bytes),
    .ld_count   (drv_ld_count)
  );

  mem_byte_lane u_lane_load (
    .mode       (mode_q),
    .offset     (off_q),
    .phase      (state == ST_PH2),
    .write_data (wd_q),
    .rdata      (bus.bus_rdata),
    .be         (ld_be),
    .wdata      (ld_wdata),
    .ld_bytes   (ld_bytes),
    .ld_count   (ld_count)
  );

  assign unused_lane = ^{ld_be, ld_wdata, drv_ld_bytes, drv_ld_count};

  // Second-beat bytes follow the first-beat bytes in address order.
  assign assembled = (state == ST_PH2) ? ((acc << {ld_count, 3'b000}) | ld_bytes)
                                       : ld_bytes;

  assign last_beat = bus.bus_ready &&
                     (((state == ST_PH1) && !split_q) || (state == ST_PH2));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (req) state_next = bad_req ? ST_DONE : ST_PH1;
      ST_PH1:  if (bus.bus_ready) state_next = split_q ? ST_PH2 : ST_DONE;
      ST_PH2:  if (bus.bus_ready) state_next = ST_DONE;
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    stall    = 1'b0;
    done     = 1'b0;
    mode_err = 1'b0;
    if (!reset) begin
      stall = ((state == ST_IDLE) && req) || (state == ST_PH1) || (state == ST_PH2);
    end
    done     = (state == ST_DONE);
    mode_err = (state == ST_DONE) && err_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mode_q        <= '0;
      off_q         <= '0;
      wd_q          <= '0;
      we_q          <= 1'b0;
      split_q       <= 1'b0;
      err_q         <= 1'b0;
      acc           <= '0;
      read_data     <= '0;
      bus.bus_req   <= 1'b0;
      bus.bus_we    <= 1'b0;
      bus.bus_addr  <= '0;
      bus.bus_be    <= '0;
      bus.bus_wdata <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req) begin
            err_q <= bad_req;
            if (!bad_req) begin
              mode_q        <= mem_mode;
              off_q         <= address[1:0];
              wd_q          <= write_data;
              we_q          <= mem_write;
              split_q       <= needs_split(mem_mode, address[1:0]);
              bus.bus_req   <= 1'b1;
              bus.bus_we    <= mem_write;
              bus.bus_addr  <= {address[ADDR_W-1:2], 2'b00};
              bus.bus_be    <= drv_be;
              bus.bus_wdata <= mem_write ? drv_wdata : '0;
            end
          end
        end
        ST_PH1: begin
          if (bus.bus_ready && split_q) begin
            acc           <= assembled;
            bus.bus_addr  <= bus.bus_addr + ADDR_W'(4);
            bus.bus_be    <= drv_be;
            bus.bus_wdata <= we_q ? drv_wdata : '0;
          end
        end
        default: ;
      endcase

      if (last_beat) begin
        bus.bus_req <= 1'b0;
        if (!we_q) read_data <= extend_load(mode_q, assembled);
      end
    end
  end

endmodule
